// File: rtl/cam_config_sequencer.sv
// Camera register configuration sequencer: walks a ROM table of {addr, data}
// pairs, issues each as a bus write, waits for ack plus a settle time, then repeats.
module cam_config_sequencer #(
  parameter int NUM_REGS      = 16,
  parameter int DIV           = 1000,
  parameter int SETTLE_TICKS  = 10,
  parameter int TIMEOUT_TICKS = 255
) (
  input  logic        ref_clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        wr_req,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  input  logic        wr_ack,
  input  logic        wr_nack,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index
);

  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH, FETCH_WAIT, ISSUE, SETTLE, DONE, ERR
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [15:0]      tick_num;
  logic [7:0]       index;
  logic             tick;
  logic [8:0]       next_index;

  assign tick       = (div_cnt == DIV_W'(DIV - 1));
  // Nine bits so that NUM_REGS = 256 is reachable without the index wrapping.
  assign next_index = {1'b0, index} + 9'd1;

  // NOTE: every state and output register lives in this one clocked block and
  // uses non-blocking assignments; later assignments in the same edge override
  // earlier ones, which is how the state-entry counter clears take effect.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      tick_num  <= '0;
      index     <= '0;
      busy      <= 1'b0;
      rom_addr  <= '0;
      wr_req    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_index <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) tick_num <= tick_num + 16'd1;

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= FETCH;
            index     <= '0;
            rom_addr  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            err_index <= '0;
          end
        end

        FETCH: state <= FETCH_WAIT;

        FETCH_WAIT: begin
          if (rom_data == 16'hFFFF) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state    <= ISSUE;
            wr_addr  <= rom_data[15:8];
            wr_data  <= rom_data[7:0];
            wr_req   <= 1'b1;
            div_cnt  <= '0;
            tick_num <= '0;
          end
        end

        // A response in the same cycle as the final timeout tick wins over the timeout.
        ISSUE: begin
          if (wr_nack || (!wr_ack && tick && tick_num == 16'(TIMEOUT_TICKS - 1))) begin
            state     <= ERR;
            wr_req    <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            err_index <= index;
          end else if (wr_ack) begin
            state    <= SETTLE;
            wr_req   <= 1'b0;
            div_cnt  <= '0;
            tick_num <= '0;
          end
        end

        SETTLE: begin
          if (tick && tick_num == 16'(SETTLE_TICKS - 1)) begin
            if (next_index == 9'(NUM_REGS)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= FETCH;
              index    <= next_index[7:0];
              rom_addr <= next_index[7:0];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_config_sequencer.sv
// Scoreboard bench for cam_config_sequencer: a table-walking reference model
// predicts writes and run outcomes; a negedge monitor compares what the DUT does.
module tb_cam_config_sequencer;

  localparam int NUM_REGS = 16;
  localparam int DIV      = 4;
  localparam int SETTLE   = 2;
  localparam int TIMEOUT  = 3;
  localparam int TO_CYC   = TIMEOUT * DIV;
  localparam int GAP_CYC  = SETTLE * DIV + 2;

  localparam int K_ACK  = 0;
  localparam int K_NACK = 1;
  localparam int K_NONE = 2;

  logic        ref_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        start   = 1'b0;
  logic        busy;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        wr_req;
  logic [7:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack  = 1'b0;
  logic        wr_nack = 1'b0;
  logic        done;
  logic        error;
  logic [7:0]  err_index;

  cam_config_sequencer #(
    .NUM_REGS(NUM_REGS), .DIV(DIV), .SETTLE_TICKS(SETTLE), .TIMEOUT_TICKS(TIMEOUT)
  ) dut (
    .ref_clk(ref_clk), .reset(reset), .start(start), .busy(busy),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_nack(wr_nack),
    .done(done), .error(error), .err_index(err_index)
  );

  always #5 ref_clk = ~ref_clk;

  logic [15:0] rom [256];
  int          plan_kind [256];
  int          plan_at   [256];

  // Registered ROM, one-cycle read latency.
  always @(posedge ref_clk) rom_data <= rom[rom_addr];

  typedef struct { logic [7:0] a; logic [7:0] d; int len; } wr_t;
  typedef struct { bit dn; bit er; logic [7:0] eidx; logic [7:0] last; } res_t;
  wr_t  exp_wr [$];
  res_t exp_res [$];

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_en    = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus responder: answers write number n on its plan_at[n]-th cycle of wr_req.
  int wn = 0, cur = 0, hi_n = 0;
  bit resp_q = 1'b0;
  always @(negedge ref_clk) begin
    if (wr_req) begin
      if (!resp_q) begin cur = wn & 255; wn++; hi_n = 0; end
      hi_n++;
      wr_ack  = (plan_kind[cur] != K_NONE) && (hi_n == plan_at[cur]);
      wr_nack = (plan_kind[cur] == K_NACK) && (hi_n == plan_at[cur]);
    end else begin
      wr_ack  = 1'b0;
      wr_nack = 1'b0;
    end
    resp_q = wr_req;
  end

  // Monitor: pops expectations whenever the DUT presents a write or ends a run.
  int  cyc = 0, busy_cyc = 0, rise_cyc = 0, fall_cyc = 0, cur_len = 0;
  bit  first_wr = 1'b0, busy_q = 1'b0, wr_q = 1'b0;
  logic [15:0] held;
  always @(negedge ref_clk) begin
    wr_t  w;
    res_t r;
    cyc++;
    if (sb_en && !reset) begin
      if (busy && !busy_q) begin
        busy_cyc = cyc;
        first_wr = 1'b1;
        check("flags_clear_at_start", {30'd0, done, error}, 32'd0);
      end
      if (wr_req && !wr_q) begin
        rise_cyc = cyc;
        held     = {wr_addr, wr_data};
        if (exp_wr.size() == 0) check("unexpected_write", {31'd0, wr_req}, 32'd0);
        else begin
          w = exp_wr.pop_front();
          cur_len = w.len;
          check("wr_addr", {24'd0, wr_addr}, {24'd0, w.a});
          check("wr_data", {24'd0, wr_data}, {24'd0, w.d});
          if (first_wr) check("start_to_wr_req", cyc - busy_cyc, 2);
          else          check("settle_gap", cyc - fall_cyc, GAP_CYC);
          first_wr = 1'b0;
        end
      end
      if (wr_req && wr_q) check("wr_stable", {16'd0, wr_addr, wr_data}, {16'd0, held});
      if (!wr_req && wr_q) begin
        fall_cyc = cyc;
        check("wr_req_len", cyc - rise_cyc, cur_len);
      end
      if (!busy && busy_q) begin
        if (exp_res.size() == 0) check("unexpected_run_end", {31'd0, busy_q}, 32'd0);
        else begin
          r = exp_res.pop_front();
          check("done", {31'd0, done}, {31'd0, r.dn});
          check("error", {31'd0, error}, {31'd0, r.er});
          if (r.er) check("err_index", {24'd0, err_index}, {24'd0, r.eidx});
          check("last_rom_addr", {24'd0, rom_addr}, {24'd0, r.last});
          check("writes_left", exp_wr.size(), 0);
        end
      end
    end
    busy_q = busy;
    wr_q   = wr_req;
  end

  // Reference model: walk the table by the rules, predicting each write and the outcome.
  task automatic build_expect();
    res_t r;
    wr_t  w;
    bit   fail;
    r.dn = 1'b1; r.er = 1'b0; r.eidx = '0; r.last = 8'(NUM_REGS - 1);
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rom[i] == 16'hFFFF) begin r.last = 8'(i); break; end
      w.a = rom[i][15:8];
      w.d = rom[i][7:0];
      if (plan_kind[i] == K_NONE || plan_at[i] > TO_CYC) begin
        w.len = TO_CYC; fail = 1'b1;
      end else begin
        w.len = plan_at[i]; fail = (plan_kind[i] == K_NACK);
      end
      exp_wr.push_back(w);
      if (fail) begin
        r.dn = 1'b0; r.er = 1'b1; r.eidx = 8'(i); r.last = 8'(i);
        break;
      end
    end
    exp_res.push_back(r);
  endtask

  task automatic fill_random(int max_at);
    for (int i = 0; i < 256; i++) begin
      rom[i]       = 16'($urandom_range(0, 16'hFFFE));
      plan_kind[i] = K_ACK;
      plan_at[i]   = $urandom_range(1, max_at);
    end
  endtask

  task automatic run(bit mid_starts);
    build_expect();
    wn    = 0;
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge ref_clk);
      start = mid_starts && busy && (i % 23 == 5);
      if (!busy) break;
    end
    start = 1'b0;
    check("run_finished", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge ref_clk);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"},  {31'd0, busy},   32'd0);
    check({tag, "_wr_req"}, {31'd0, wr_req}, 32'd0);
    check({tag, "_flags"}, {30'd0, done, error}, 32'd0);
    check({tag, "_addrs"}, {rom_addr, wr_addr, wr_data, err_index}, 32'd0);
  endtask

  task automatic reset_scenario(bit in_settle);
    int seen;
    sb_en = 1'b0;
    fill_random(3);
    wn    = 0;
    start = 1'b1;
    @(negedge ref_clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !wr_req; i++) @(negedge ref_clk);
    check("reached_issue", {31'd0, wr_req}, 32'd1);
    if (in_settle) begin
      for (int i = 0; i < 50 && wr_req; i++) @(negedge ref_clk);
      repeat (3) @(negedge ref_clk);
      check("in_settle_busy", {31'd0, busy}, 32'd1);
    end
    reset = 1'b1;
    start = 1'b1;
    @(negedge ref_clk);
    check_all_zero(in_settle ? "rst_settle" : "rst_issue");
    start = 1'b0;
    @(negedge ref_clk);
    reset = 1'b0;
    seen  = 0;
    repeat (20) begin
      @(negedge ref_clk);
      seen += int'(wr_req) + int'(busy);
    end
    check("idle_after_reset", seen, 0);
    sb_en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_random(8);
    repeat (3) @(negedge ref_clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge ref_clk);
    check_all_zero("idle");
    sb_en = 1'b1;

    // Three-entry table with end marker.
    rom[0] = 16'h1234; rom[1] = 16'h5678; rom[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin plan_kind[i] = K_ACK; plan_at[i] = 4; end
    run(1'b0);

    // Full table without marker, ack on the final timeout cycle for one entry, starts while busy.
    fill_random(8);
    plan_at[7] = TO_CYC;
    run(1'b1);

    // Nack (with ack) on entry 2.
    fill_random(6);
    plan_kind[2] = K_NACK;
    plan_at[2]   = 3;
    run(1'b0);

    // Restart from ERR; no response on entry 0 -> timeout.
    fill_random(6);
    plan_kind[0] = K_NONE;
    run(1'b0);

    // Restart from ERR into a clean run, then restart from DONE with marker at entry 0.
    fill_random(6);
    rom[5] = 16'hFFFF;
    run(1'b0);
    fill_random(6);
    rom[0] = 16'hFFFF;
    run(1'b0);

    reset_scenario(1'b0);
    reset_scenario(1'b1);

    // Randomized runs: random marker position, occasional nack or late/no response.
    for (int t = 0; t < 8; t++) begin
      fill_random(TO_CYC + 2);
      if ($urandom_range(0, 1) == 1) rom[$urandom_range(0, NUM_REGS - 1)] = 16'hFFFF;
      for (int i = 0; i < NUM_REGS; i++)
        if ($urandom_range(0, 15) == 0) plan_kind[i] = $urandom_range(1, 2);
      run(t[0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_config_sequencer.md
CAM_CONFIG_SEQUENCER -- requirements
Module: cam_config_sequencer

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: maximum table entries walked per run (1..256).
REQ-002 SHALL have parameter DIV, default 1000: ref_clk cycles per timing tick (>=2; 100 MHz gives 100 kHz).
REQ-003 SHALL have parameter SETTLE_TICKS, default 10: ticks waited after each acknowledged write (>=1).
REQ-004 SHALL have parameter TIMEOUT_TICKS, default 255: ticks allowed for wr_ack/wr_nack before abort (>=1).
REQ-005 SHALL have ports ref_clk input 1 (sole clock, rising edge) and reset input 1 (synchronous, active-high), listed first.
REQ-006 SHALL have ports start input 1 (run request pulse) and busy output 1 (run in progress).
REQ-007 SHALL have ports rom_addr output 8 (table index) and rom_data input 16 ({reg_addr[15:8], reg_data[7:0]}, registered ROM, 1-cycle read latency).
REQ-008 SHALL have ports wr_req output 1, wr_addr output 8, wr_data output 8 (write request to serial bus engine).
REQ-009 SHALL have ports wr_ack input 1 (write accepted) and wr_nack input 1 (write refused).
REQ-010 SHALL have ports done output 1 (last run completed), error output 1 (last run aborted), err_index output 8 (index of failing entry).

Function
REQ-011 SHALL implement states IDLE, FETCH, FETCH_WAIT, ISSUE, SETTLE, DONE, ERR.
REQ-012 IDLE/DONE/ERR: start=1 at an edge -> index=0, FETCH, busy=1, done=0, error=0 from that edge; start ignored in all other states.
REQ-013 FETCH: rom_addr=index, one cycle -> FETCH_WAIT; FETCH_WAIT: one cycle -> ISSUE, latching rom_data into wr_addr/wr_data at the entry edge.
REQ-014 SHALL treat latched entry 16'hFFFF as end marker: FETCH_WAIT -> DONE instead of ISSUE, no write issued.
REQ-015 wr_req SHALL be 1 throughout ISSUE, 0 elsewhere; wr_addr/wr_data SHALL be stable while wr_req=1.
REQ-016 Start sampled at edge k -> wr_req rises at edge k+2 (for a non-marker entry).
REQ-017 ISSUE: wr_ack=1 -> SETTLE; wr_nack=1 -> ERR; both high same cycle -> nack wins (ERR); wr_req low from the following edge.
REQ-018 Tick counter: cleared to 0 on entry to ISSUE and SETTLE; increments each cycle; at DIV-1 emits a 1-cycle tick and wraps to 0.
REQ-019 ISSUE SHALL count ticks; TIMEOUT_TICKS-th tick with no ack/nack -> ERR; an ack/nack in that same cycle takes priority over timeout.
REQ-020 SETTLE: after SETTLE_TICKS ticks, index+1; if new index == NUM_REGS -> DONE, else FETCH.
REQ-021 Index SHALL be 8 bits, never wrap past NUM_REGS-1 during a run.
REQ-022 ERR: error=1, err_index=index of failing entry, busy=0; held until next start or reset.
REQ-023 DONE: done=1, busy=0; held until next start or reset.
REQ-024 busy SHALL be 1 exactly in FETCH, FETCH_WAIT, ISSUE, SETTLE.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, index=0, tick counter=0, and all outputs 0 (busy, done, error, wr_req, wr_addr, wr_data, rom_addr, err_index) from that edge, overriding start.
REQ-026 Reset mid-ISSUE SHALL drop wr_req at the same edge; no further write issued until a new start.

Verification
REQ-027 3-entry table {1234,5678,FFFF}, DIV=4, SETTLE_TICKS=2, ack 3 cycles after each wr_req -> writes (12,34),(56,78) in order, 8 cycles of SETTLE each, done=1, error=0.
REQ-028 Full 16-entry table without marker -> exactly 16 writes, rom_addr 0..15, done at index 16, no 17th fetch.
REQ-029 wr_nack on entry 2 (wr_ack also high same cycle) -> error=1, err_index=2, done=0, wr_req low next edge.
REQ-030 No ack, DIV=4, TIMEOUT_TICKS=3 -> wr_req high exactly 12 cycles, then error=1, err_index=0.
REQ-031 Reset asserted during ISSUE and SETTLE; start pulsed while busy -> all outputs 0 at reset edge; mid-run start has no effect on index.
REQ-032 start in DONE and in ERR -> restart from index 0 with done/error cleared at start edge.
